// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and default responder address.
package i2c_pkg;
    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h42;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        RX       = 3'd3,
        RX_ACK   = 3'd4,
        TX       = 3'd5,
        TX_ACK   = 3'd6,
        IGNORE   = 3'd7
    } i2c_state_e;
endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronisers for SDA/SCL plus SCL edge and START/STOP detection.
module i2c_bus_sync (
    input  logic clock,
    input  logic rst_n,
    input  logic i_sda,
    input  logic i_scl,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);
    logic [1:0] r_sda_sync;
    logic [1:0] r_scl_sync;
    logic       r_sda_d;
    logic       r_scl_d;
    logic       w_scl;

    // Idle bus level is high, so everything resets to 1 to avoid phantom edges.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_sda_sync <= 2'b11;
            r_scl_sync <= 2'b11;
            r_sda_d    <= 1'b1;
            r_scl_d    <= 1'b1;
        end else begin
            r_sda_sync <= {r_sda_sync[0], i_sda};
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_d    <= r_sda_sync[1];
            r_scl_d    <= r_scl_sync[1];
        end
    end

    assign o_sda      = r_sda_sync[1];
    assign w_scl      = r_scl_sync[1];
    assign o_scl_rise = w_scl & ~r_scl_d;
    assign o_scl_fall = ~w_scl & r_scl_d;
    assign o_start    = r_sda_d & ~o_sda & w_scl & r_scl_d;
    assign o_stop     = ~r_sda_d & o_sda & w_scl & r_scl_d;
endmodule

// File: rtl/i2c_slave.sv
// I2C responder with 7-bit address, byte rx/tx handshakes and debug strobes.
// Define I2C_SLAVE_STRETCH_EN to stretch SCL while waiting for a tx byte.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = i2c_pkg::DEFAULT_SLAVE_ADDR
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       SDA_i,
    input  logic       SCL_i,
    output logic       SDA_t,
    output logic       SCL_t,
    output logic       SDA_o,
    output logic       SCL_o,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy,
    output logic       rw,
    output logic       nack_recv,
    output logic [2:0] state
);
    import i2c_pkg::*;

    logic       w_sda, w_scl_rise, w_scl_fall, w_start, w_stop, w_hs, w_load;
    i2c_state_e r_state, w_state_n;
    logic [3:0] r_bitcnt, w_bitcnt_n;
    logic [7:0] r_shift, w_shift_n;
    logic [7:0] r_rx_data, w_rx_data_n;
    logic [7:0] r_tx_byte, w_tx_byte_n;
    logic       r_sda_t, w_sda_t_n;
    logic       r_phase, w_phase_n;
    logic       r_rw, w_rw_n;
    logic       r_rx_valid, w_rx_valid_n;
    logic       r_tx_have, w_tx_have_n;
    logic       r_nack, w_nack_n;
    logic       r_stretch, w_stretch_n;
    logic       r_start_det, r_stop_det;

    i2c_bus_sync u_sync (
        .clock      (clock),
        .rst_n      (rst_n),
        .i_sda      (SDA_i),
        .i_scl      (SCL_i),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign w_hs = tx_valid & tx_ready;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_tx_byte   <= '0;
            r_sda_t     <= 1'b1;
            r_phase     <= 1'b0;
            r_rw        <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_tx_have   <= 1'b0;
            r_nack      <= 1'b0;
            r_stretch   <= 1'b0;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_bitcnt    <= w_bitcnt_n;
            r_shift     <= w_shift_n;
            r_rx_data   <= w_rx_data_n;
            r_tx_byte   <= w_tx_byte_n;
            r_sda_t     <= w_sda_t_n;
            r_phase     <= w_phase_n;
            r_rw        <= w_rw_n;
            r_rx_valid  <= w_rx_valid_n;
            r_tx_have   <= w_tx_have_n;
            r_nack      <= w_nack_n;
            r_stretch   <= w_stretch_n;
            r_start_det <= w_start;
            r_stop_det  <= w_stop;
        end
    end

    // r_phase marks the second half of an ACK slot (ours driven, or master ACK seen).
    always_comb begin
        w_state_n    = r_state;
        w_bitcnt_n   = r_bitcnt;
        w_shift_n    = r_shift;
        w_rx_data_n  = r_rx_data;
        w_tx_byte_n  = r_tx_byte;
        w_sda_t_n    = r_sda_t;
        w_phase_n    = r_phase;
        w_rw_n       = r_rw;
        w_rx_valid_n = 1'b0;
        w_tx_have_n  = r_tx_have;
        w_nack_n     = 1'b0;
        w_stretch_n  = r_stretch;
        w_load       = 1'b0;
        if (w_hs) begin
            w_tx_byte_n = tx_data;
            w_tx_have_n = 1'b1;
        end
        if (w_start || w_stop) begin
            w_state_n   = w_start ? ADDR : IDLE;
            w_bitcnt_n  = '0;
            w_sda_t_n   = 1'b1;
            w_phase_n   = 1'b0;
            w_stretch_n = 1'b0;
            w_tx_have_n = 1'b0;
        end else begin
            case (r_state)
                ADDR: if (w_scl_rise) begin
                    w_shift_n  = {r_shift[6:0], w_sda};
                    w_bitcnt_n = r_bitcnt + 4'd1;
                    if (r_bitcnt == 4'd7) begin
                        if (r_shift[6:0] == SLAVE_ADDR) begin
                            w_rw_n    = w_sda;
                            w_phase_n = 1'b0;
                            w_state_n = ADDR_ACK;
                        end else begin
                            w_state_n = IGNORE;
                        end
                    end
                end
                ADDR_ACK: if (w_scl_fall) begin
                    if (!r_phase) begin
                        w_sda_t_n = 1'b0;
                        w_phase_n = 1'b1;
                    end else if (r_rw) begin
                        w_load = 1'b1;
                    end else begin
                        w_sda_t_n  = 1'b1;
                        w_phase_n  = 1'b0;
                        w_bitcnt_n = '0;
                        w_state_n  = RX;
                    end
                end
                RX: if (w_scl_rise) begin
                    w_shift_n  = {r_shift[6:0], w_sda};
                    w_bitcnt_n = r_bitcnt + 4'd1;
                    if (r_bitcnt == 4'd7) begin
                        w_rx_data_n  = {r_shift[6:0], w_sda};
                        w_rx_valid_n = 1'b1;
                        w_phase_n    = 1'b0;
                        w_state_n    = RX_ACK;
                    end
                end
                RX_ACK: if (w_scl_fall) begin
                    if (!r_phase) begin
                        w_sda_t_n = 1'b0;
                        w_phase_n = 1'b1;
                    end else begin
                        w_sda_t_n  = 1'b1;
                        w_phase_n  = 1'b0;
                        w_bitcnt_n = '0;
                        w_state_n  = RX;
                    end
                end
                TX: if (r_stretch) begin
                    if (w_hs) begin
                        w_shift_n   = tx_data;
                        w_sda_t_n   = tx_data[7];
                        w_stretch_n = 1'b0;
                        w_tx_have_n = 1'b0;
                    end
                end else if (w_scl_rise) begin
                    w_bitcnt_n = r_bitcnt + 4'd1;
                end else if (w_scl_fall) begin
                    if (r_bitcnt == 4'd8) begin
                        w_sda_t_n  = 1'b1;
                        w_phase_n  = 1'b0;
                        w_bitcnt_n = '0;
                        w_state_n  = TX_ACK;
                    end else begin
                        w_shift_n = {r_shift[6:0], 1'b0};
                        w_sda_t_n = r_shift[6];
                    end
                end
                TX_ACK: if (w_scl_rise) begin
                    if (w_sda) begin
                        w_nack_n  = 1'b1;
                        w_state_n = IGNORE;
                    end else begin
                        w_phase_n = 1'b1;
                    end
                end else if (w_scl_fall && r_phase) begin
                    w_load = 1'b1;
                end
                default: ;
            endcase
            // First bit of a read byte goes out on the falling edge that ends the ACK slot.
            if (w_load) begin
                w_state_n   = TX;
                w_bitcnt_n  = '0;
                w_phase_n   = 1'b0;
                w_tx_have_n = 1'b0;
                if (r_tx_have) begin
                    w_shift_n = r_tx_byte;
                    w_sda_t_n = r_tx_byte[7];
                end else if (w_hs) begin
                    w_shift_n = tx_data;
                    w_sda_t_n = tx_data[7];
                end else begin
`ifdef I2C_SLAVE_STRETCH_EN
                    w_stretch_n = 1'b1;
                    w_sda_t_n   = 1'b1;
`else
                    w_shift_n   = 8'hFF;
                    w_sda_t_n   = 1'b1;
`endif
                end
            end
        end
    end

    assign tx_ready  = !r_tx_have && ((r_state == ADDR_ACK && r_rw) || r_state == TX_ACK ||
                                      (r_state == TX && r_stretch));
    assign busy      = r_state inside {ADDR_ACK, RX, RX_ACK, TX, TX_ACK};
    assign SDA_t     = r_sda_t;
`ifdef I2C_SLAVE_STRETCH_EN
    assign SCL_t     = ~r_stretch;
`else
    assign SCL_t     = 1'b1;
`endif
    assign SDA_o     = 1'b0;
    assign SCL_o     = 1'b0;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign start_det = r_start_det;
    assign stop_det  = r_stop_det;
    assign rw        = r_rw;
    assign nack_recv = r_nack;
    assign state     = r_state;
endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bus-level master model with open-drain wiring.
module tb_i2c_slave;
    localparam int Q = 20;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       m_sda, m_scl;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       SDA_t, SCL_t, SDA_o, SCL_o;
    logic [7:0] rx_data;
    logic       rx_valid, tx_ready, start_det, stop_det, busy, rw, nack_recv;
    logic [2:0] state;
    wire        sda_line = m_sda & SDA_t;
    wire        scl_line = m_scl & SCL_t;

    int n_chk = 0, n_pass = 0;
    int rxv_cnt = 0, st_cnt = 0, sp_cnt = 0, nack_cnt = 0, sda_low_cnt = 0, scl_low_cnt = 0;

    i2c_slave #(.SLAVE_ADDR(7'h42)) dut (
        .clock(clock), .rst_n(rst_n), .SDA_i(sda_line), .SCL_i(scl_line),
        .SDA_t(SDA_t), .SCL_t(SCL_t), .SDA_o(SDA_o), .SCL_o(SCL_o),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .start_det(start_det), .stop_det(stop_det), .busy(busy),
        .rw(rw), .nack_recv(nack_recv), .state(state)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (rx_valid)  rxv_cnt++;
        if (start_det) st_cnt++;
        if (stop_det)  sp_cnt++;
        if (nack_recv) nack_cnt++;
        if (!SDA_t)    sda_low_cnt++;
        if (!SCL_t)    scl_low_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic scl_high();
        m_scl = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (scl_line) break;
            @(negedge clock);
        end
        if (!scl_line) begin
            n_chk++;
            $display("FAIL scl_release_timeout got scl=%0b want 1", scl_line);
        end
    endtask

    task automatic wr_bit(input logic b);
        m_sda = b; wait_clk(Q); scl_high(); wait_clk(2*Q); m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic rd_bit(output logic b);
        m_sda = 1'b1; wait_clk(Q); scl_high(); wait_clk(Q);
        b = sda_line;
        wait_clk(Q); m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wr_bit(d[i]);
        rd_bit(ack);
    endtask

    task automatic rd_byte(input logic ack_in, output logic [7:0] d);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            rd_bit(b);
            d = {d[6:0], b};
        end
        wr_bit(ack_in);
    endtask

    task automatic bus_start();
        if (!m_scl) begin
            m_sda = 1'b1; wait_clk(Q); scl_high(); wait_clk(Q);
        end
        m_sda = 1'b0; wait_clk(Q); m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wait_clk(Q); scl_high(); wait_clk(Q); m_sda = 1'b1; wait_clk(Q);
    endtask

    task automatic tx_offer(input logic [7:0] d);
        bit done = 1'b0;
        tx_data = d; tx_valid = 1'b1;
        for (int i = 0; i < 4000 && !done; i++) begin
            if (tx_ready) done = 1'b1;
            @(negedge clock);
        end
        tx_valid = 1'b0;
        if (!done) begin
            n_chk++;
            $display("FAIL tx_handshake_timeout byte=%02h got no tx_ready want handshake", d);
        end
    endtask

    task automatic test_reset();
        n_chk++; if ({SDA_t, SCL_t, SDA_o, SCL_o} !== 4'b1100) $display("FAIL reset_lines got %b want 1100", {SDA_t, SCL_t, SDA_o, SCL_o}); else n_pass++;
        n_chk++; if (state !== 3'd0) $display("FAIL reset_state got %0d want 0", state); else n_pass++;
        n_chk++; if ({busy, rx_valid, tx_ready, rw, start_det, stop_det, nack_recv} !== 7'b0) $display("FAIL reset_flags got %b want 0000000", {busy, rx_valid, tx_ready, rw, start_det, stop_det, nack_recv}); else n_pass++;
        n_chk++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %02h want 00", rx_data); else n_pass++;
    endtask

    task automatic test_write();
        logic a0, a1; logic b_mid;
        int rxv0, sp0;
        rxv0 = rxv_cnt; sp0 = sp_cnt;
        bus_start(); wr_byte(8'h84, a0); b_mid = busy; wr_byte(8'hA5, a1);
        n_chk++; if (a0 !== 1'b0) $display("FAIL wr_addr_ack got %0b want 0", a0); else n_pass++;
        n_chk++; if (a1 !== 1'b0) $display("FAIL wr_data_ack got %0b want 0", a1); else n_pass++;
        n_chk++; if (b_mid !== 1'b1) $display("FAIL wr_busy got %0b want 1", b_mid); else n_pass++;
        n_chk++; if (rx_data !== 8'hA5) $display("FAIL wr_rx_data got %02h want a5", rx_data); else n_pass++;
        n_chk++; if (rxv_cnt - rxv0 !== 1) $display("FAIL wr_rx_valid_count got %0d want 1", rxv_cnt - rxv0); else n_pass++;
        bus_stop(); wait_clk(5);
        n_chk++; if (busy !== 1'b0) $display("FAIL wr_busy_after_stop got %0b want 0", busy); else n_pass++;
        n_chk++; if (sp_cnt - sp0 !== 1) $display("FAIL wr_stop_det_count got %0d want 1", sp_cnt - sp0); else n_pass++;
    endtask

    task automatic test_mismatch();
        logic a0, a1; logic [2:0] s0, s1;
        int rxv0, low0;
        rxv0 = rxv_cnt; low0 = sda_low_cnt;
        bus_start(); wr_byte(8'h86, a0); s0 = state; wr_byte(8'h5A, a1); s1 = state;
        n_chk++; if (a0 !== 1'b1) $display("FAIL mm_addr_ack got %0b want 1", a0); else n_pass++;
        n_chk++; if ({s0, s1} !== {3'd7, 3'd7}) $display("FAIL mm_state got %0d,%0d want 7,7", s0, s1); else n_pass++;
        n_chk++; if (a1 !== 1'b1) $display("FAIL mm_data_ack got %0b want 1", a1); else n_pass++;
        bus_stop(); wait_clk(5);
        n_chk++; if (sda_low_cnt - low0 !== 0) $display("FAIL mm_sda_low_cycles got %0d want 0", sda_low_cnt - low0); else n_pass++;
        n_chk++; if (rxv_cnt - rxv0 !== 0) $display("FAIL mm_rx_valid_count got %0d want 0", rxv_cnt - rxv0); else n_pass++;
        n_chk++; if (state !== 3'd0) $display("FAIL mm_state_after_stop got %0d want 0", state); else n_pass++;
    endtask

    task automatic test_read();
        logic a0, rw_s; logic [7:0] d0, d1; logic [2:0] s_nack;
        int nk0;
        nk0 = nack_cnt;
        fork
            begin tx_offer(8'h3C); tx_offer(8'h81); end
            begin
                bus_start(); wr_byte(8'h85, a0); rw_s = rw;
                rd_byte(1'b0, d0); rd_byte(1'b1, d1); s_nack = state;
                bus_stop(); wait_clk(5);
            end
        join
        n_chk++; if (a0 !== 1'b0) $display("FAIL rd_addr_ack got %0b want 0", a0); else n_pass++;
        n_chk++; if (rw_s !== 1'b1) $display("FAIL rd_rw got %0b want 1", rw_s); else n_pass++;
        n_chk++; if (d0 !== 8'h3C) $display("FAIL rd_byte0 got %02h want 3c", d0); else n_pass++;
        n_chk++; if (d1 !== 8'h81) $display("FAIL rd_byte1 got %02h want 81", d1); else n_pass++;
        n_chk++; if (nack_cnt - nk0 !== 1) $display("FAIL rd_nack_count got %0d want 1", nack_cnt - nk0); else n_pass++;
        n_chk++; if (s_nack !== 3'd7) $display("FAIL rd_state_after_nack got %0d want 7", s_nack); else n_pass++;
    endtask

    task automatic test_repeated_start();
        logic a0, a1, a2, rw_w, rw_r; logic [7:0] d;
        int st0;
        st0 = st_cnt;
        fork
            tx_offer(8'h77);
            begin
                bus_start(); wr_byte(8'h84, a0); wr_byte(8'h11, a1); rw_w = rw;
                bus_start(); wr_byte(8'h85, a2); rw_r = rw;
                rd_byte(1'b1, d); bus_stop(); wait_clk(5);
            end
        join
        n_chk++; if ({a0, a1, a2} !== 3'b000) $display("FAIL rs_acks got %b want 000", {a0, a1, a2}); else n_pass++;
        n_chk++; if ({rw_w, rw_r} !== 2'b01) $display("FAIL rs_rw got %b want 01", {rw_w, rw_r}); else n_pass++;
        n_chk++; if (st_cnt - st0 !== 2) $display("FAIL rs_start_det_count got %0d want 2", st_cnt - st0); else n_pass++;
        n_chk++; if (rx_data !== 8'h11) $display("FAIL rs_rx_data got %02h want 11", rx_data); else n_pass++;
        n_chk++; if (d !== 8'h77) $display("FAIL rs_read_byte got %02h want 77", d); else n_pass++;
    endtask

    task automatic test_stretch();
        logic a0; logic [7:0] d;
        int sl0, sl;
        sl0 = scl_low_cnt;
        fork
            begin
                for (int i = 0; i < 5000; i++) begin
                    if (state == 3'd5) break;
                    @(negedge clock);
                end
                repeat (200) @(negedge clock);
                tx_offer(8'h5A);
            end
            begin
                bus_start(); wr_byte(8'h85, a0); rd_byte(1'b1, d); bus_stop(); wait_clk(5);
            end
        join
        sl = scl_low_cnt - sl0;
        n_chk++; if (a0 !== 1'b0) $display("FAIL st_addr_ack got %0b want 0", a0); else n_pass++;
`ifdef I2C_SLAVE_STRETCH_EN
        n_chk++; if (sl < 197 || sl > 203) $display("FAIL st_scl_low_cycles got %0d want 197..203", sl); else n_pass++;
        n_chk++; if (d !== 8'h5A) $display("FAIL st_read_byte got %02h want 5a", d); else n_pass++;
`else
        n_chk++; if (sl !== 0) $display("FAIL st_scl_low_cycles got %0d want 0", sl); else n_pass++;
        n_chk++; if (d !== 8'hFF) $display("FAIL st_read_byte got %02h want ff", d); else n_pass++;
`endif
    endtask

    task automatic test_reset_midrx();
        logic a0, a1, a2, a3; logic pre_sda, post_sda; logic [2:0] post_st;
        int low0, rxv0;
        bus_start(); wr_byte(8'h84, a0);
        for (int i = 7; i >= 0; i--) wr_bit(8'hC3 >> i);
        m_sda = 1'b1; wait_clk(Q);
        pre_sda = SDA_t;
        rst_n = 1'b0; #1;
        post_sda = SDA_t; post_st = state;
        n_chk++; if ({a0, pre_sda} !== 2'b00) $display("FAIL rr_ack_before_reset got %b want 00", {a0, pre_sda}); else n_pass++;
        n_chk++; if (post_sda !== 1'b1) $display("FAIL rr_sda_release got %0b want 1", post_sda); else n_pass++;
        n_chk++; if (post_st !== 3'd0) $display("FAIL rr_state_in_reset got %0d want 0", post_st); else n_pass++;
        wait_clk(3); rst_n = 1'b1; wait_clk(3);
        low0 = sda_low_cnt; rxv0 = rxv_cnt;
        wr_byte(8'h84, a1); wr_byte(8'h99, a2);
        n_chk++; if ({a1, a2} !== 2'b11) $display("FAIL rr_no_start_acks got %b want 11", {a1, a2}); else n_pass++;
        n_chk++; if (sda_low_cnt - low0 !== 0) $display("FAIL rr_no_start_sda_low got %0d want 0", sda_low_cnt - low0); else n_pass++;
        n_chk++; if (rxv_cnt - rxv0 !== 0) $display("FAIL rr_no_start_rx_valid got %0d want 0", rxv_cnt - rxv0); else n_pass++;
        n_chk++; if (state !== 3'd0) $display("FAIL rr_no_start_state got %0d want 0", state); else n_pass++;
        bus_stop(); bus_start(); wr_byte(8'h84, a3); wr_byte(8'h3E, a0); bus_stop(); wait_clk(5);
        n_chk++; if ({a3, a0} !== 2'b00) $display("FAIL rr_fresh_acks got %b want 00", {a3, a0}); else n_pass++;
        n_chk++; if (rx_data !== 8'h3E) $display("FAIL rr_fresh_rx_data got %02h want 3e", rx_data); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; m_sda = 1'b1; m_scl = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        wait_clk(5);
        test_reset();
        rst_n = 1'b1;
        wait_clk(5);
        test_write();
        test_mismatch();
        test_read();
        test_repeated_start();
        test_stretch();
        test_reset_midrx();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter: SLAVE_ADDR, 7'h42, 7-bit address this responder answers to.
REQ-002 SHALL have port: clock  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: SDA_i, SCL_i  input  1 each  raw bus levels.
REQ-005 SHALL have ports: SDA_t, SCL_t  output  1 each  1 = release line, 0 = drive low.
REQ-006 SHALL have ports: SDA_o, SCL_o  output  1 each  tied 0.
REQ-007 SHALL have ports: rx_data  output  8  last written byte; rx_valid  output  1  one-cycle strobe.
REQ-008 SHALL have ports: tx_data  input  8  byte to return; tx_valid  input  1; tx_ready  output  1  tx_data accepted when tx_valid & tx_ready.
REQ-009 SHALL have ports: start_det, stop_det  output  1 each  one-cycle strobes; busy  output  1  addressed transaction active; rw  output  1  direction latched from the address byte; nack_recv  output  1  master NACKed a read byte (strobe).
REQ-010 SHALL have port: state  output  3  current FSM state, for debug.

Function
REQ-011 SHALL pass SDA_i and SCL_i through 2-FF synchronisers, then 1-cycle-delayed copies for edge detection.
REQ-012 SHALL detect START as synced SDA falling while SCL high, STOP as SDA rising while SCL high; both override any state in the same cycle.
REQ-013 SHALL use states IDLE=0, ADDR=1, ADDR_ACK=2, RX=3, RX_ACK=4, TX=5, TX_ACK=6, IGNORE=7.
REQ-014 SHALL on START (incl. repeated START) go to ADDR with bit counter 0; on STOP go to IDLE and release SDA/SCL.
REQ-015 SHALL sample SDA on SCL rising edge, MSB first, and change its driven SDA only after SCL falling edge.
REQ-016 SHALL in ADDR shift 8 bits; on match of bits[7:1] with SLAVE_ADDR latch rw=bit0 and go to ADDR_ACK; on mismatch go to IGNORE (releases SDA until next START/STOP).
REQ-017 SHALL in ADDR_ACK drive SDA low for one SCL period (falling edge to falling edge), then go to RX if rw=0, TX if rw=1.
REQ-018 SHALL in RX on 8th rising edge update rx_data, pulse rx_valid the following cycle, then ACK in RX_ACK and return to RX.
REQ-019 SHALL assert tx_ready in ADDR_ACK (rw=1) and TX_ACK until handshake; accepted byte shifted out MSB first in TX.
REQ-020 SHALL in TX_ACK release SDA and sample master ACK on SCL rising edge: ACK (0) -> TX; NACK (1) -> pulse nack_recv, go to IGNORE.
REQ-021 SHALL assert busy in ADDR_ACK, RX, RX_ACK, TX, TX_ACK.
REQ-022 SHALL never drive SDA low while in IDLE, ADDR or IGNORE.

Reset
REQ-023 SHALL on rst_n low immediately set state=IDLE, SDA_t=1, SCL_t=1, SDA_o=0, SCL_o=0, rx_data=0, rx_valid=0, tx_ready=0, start_det=0, stop_det=0, busy=0, rw=0, nack_recv=0, synchronisers to 1.
REQ-024 SHALL, on reset mid-transfer, release both lines in the same cycle and require a fresh START to respond.

Configuration
REQ-025 SHALL with I2C_SLAVE_STRETCH_EN defined hold SCL_t=0 after the SCL falling edge that begins TX when no tx byte is accepted, releasing it the cycle after handshake.
REQ-026 SHALL without I2C_SLAVE_STRETCH_EN keep SCL_t=1 permanently and transmit 8'hFF when no byte was accepted by that falling edge.

Structure
REQ-027 SHALL place state encoding and DEFAULT_SLAVE_ADDR in package i2c_pkg, shared with the master.
REQ-028 SHALL implement synchroniser plus START/STOP/edge detection as sub-module i2c_bus_sync.

Verification
REQ-029 SHALL check: write addr 0x42, data 0xA5 -> ACK on both bytes, rx_valid once, rx_data=0xA5, busy drops after STOP.
REQ-030 SHALL check: addr 0x43 (mismatch) -> SDA never driven low, no rx_valid, state IGNORE until STOP.
REQ-031 SHALL check: read from 0x42 with tx_data 0x3C then 0x81, master ACK then NACK -> bus bits 0x3C,0x81, nack_recv one pulse, state IGNORE.
REQ-032 SHALL check: write 0x11, repeated START, read -> rw flips to 1, start_det pulses twice.
REQ-033 SHALL check: STRETCH_EN, tx_valid delayed 200 cycles -> SCL held low 200±3 cycles, then 0xXX transmitted correctly; without macro -> 0xFF.
REQ-034 SHALL check: rst_n asserted during RX_ACK -> SDA_t=1 within same cycle, no further responses until new START.
